// File: rtl/playfield_matrix_mem.sv
// Playfield store: line ports, window read, piece stamp, row clear.
// Row 0 is the top row; bit c of a row is column c.
module playfield_matrix_mem #(
  parameter int width_p          = 10,
  parameter int height_p         = 20,
  parameter int piece_dim_p      = 4,
  parameter int num_line_ports_p = 2,
  localparam int XW = $clog2(width_p) + 1,
  localparam int YW = $clog2(height_p) + 1,
  localparam int AW = $clog2(height_p)
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [num_line_ports_p-1:0]               line_v_i,
  input  logic [num_line_ports_p-1:0][AW-1:0]       line_addr_i,
  output logic [num_line_ports_p-1:0][width_p-1:0]  line_data_o,
  input  logic [XW-1:0]                             win_x_i,
  input  logic [YW-1:0]                             win_y_i,
  output logic [piece_dim_p-1:0][piece_dim_p-1:0]   win_data_o,
  input  logic                                      wr_v_i,
  input  logic [AW-1:0]                             wr_addr_i,
  input  logic [width_p-1:0]                        wr_data_i,
  output logic                                      wr_ready_o,
  input  logic                                      blk_v_i,
  input  logic [XW-1:0]                             blk_x_i,
  input  logic [YW-1:0]                             blk_y_i,
  input  logic [piece_dim_p-1:0][piece_dim_p-1:0]   blk_data_i,
  output logic                                      blk_ready_o,
  output logic                                      blk_done_o,
  input  logic                                      clr_v_i,
  output logic                                      clr_ready_o,
  output logic                                      clr_done_o,
  output logic [YW-1:0]                             lines_cleared_o
);

  localparam int CW = $clog2(width_p);
  localparam int KW = (piece_dim_p > 1) ? $clog2(piece_dim_p) : 1;
  localparam logic [AW:0] HGT = (AW+1)'(height_p);

  typedef enum logic [1:0] {IDLE, STAMP, SCAN, FILL} state_e;

  state_e state_r, state_n;

  logic [width_p-1:0] mem [height_p];

  logic [num_line_ports_p-1:0][AW-1:0] addr_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [piece_dim_p-1:0][piece_dim_p-1:0] mask_r;
  logic [KW-1:0] k_r, k_n;
  logic [AW-1:0] src_r, src_n, dst_r, dst_n, fill_r, fill_n;
  logic [YW-1:0] cnt_r, cnt_n, lc_r, lc_d;
  logic lc_we;

  logic we;
  logic [AW-1:0] wa;
  logic [width_p-1:0] wd;

  logic blk_acc, clr_acc, wr_acc;
  logic [width_p-1:0] smask;
  int sy;

  assign blk_ready_o = (state_r == IDLE);
  assign clr_ready_o = (state_r == IDLE) & ~blk_v_i;
  assign wr_ready_o  = (state_r == IDLE) & ~blk_v_i & ~clr_v_i;

  assign blk_acc = blk_v_i & blk_ready_o;
  assign clr_acc = clr_v_i & clr_ready_o;
  assign wr_acc  = wr_v_i & wr_ready_o;

  assign lines_cleared_o = lc_r;

  // Current mask row placed at column x; columns past the wall drop out.
  always_comb begin
    smask = '0;
    sy = int'(y_r) + int'(k_r);
    for (int c = 0; c < width_p; c++) begin
      for (int j = 0; j < piece_dim_p; j++) begin
        if (int'(x_r) + j == c) smask[c] = smask[c] | mask_r[k_r][j];
      end
    end
  end

  always_comb begin
    state_n    = state_r;
    k_n        = k_r;
    src_n      = src_r;
    dst_n      = dst_r;
    cnt_n      = cnt_r;
    fill_n     = fill_r;
    we         = 1'b0;
    wa         = wr_addr_i;
    wd         = wr_data_i;
    lc_we      = 1'b0;
    lc_d       = cnt_r;
    blk_done_o = 1'b0;
    clr_done_o = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (blk_acc) begin
          state_n = STAMP;
          k_n     = '0;
        end else if (clr_acc) begin
          state_n = SCAN;
          src_n   = AW'(height_p - 1);
          dst_n   = AW'(height_p - 1);
          cnt_n   = '0;
        end else if (wr_acc && ({1'b0, wr_addr_i} < HGT)) begin
          we = 1'b1;
        end
      end
      STAMP: begin
        if (sy < height_p) begin
          we = 1'b1;
          wa = AW'(sy);
          wd = mem[AW'(sy)] | smask;
        end
        k_n = k_r + 1'b1;
        if (k_r == KW'(piece_dim_p - 1)) begin
          blk_done_o = 1'b1;
          state_n    = IDLE;
        end
      end
      SCAN: begin
        if (&mem[src_r]) begin
          cnt_n = cnt_r + 1'b1;
        end else begin
          we    = 1'b1;
          wa    = dst_r;
          wd    = mem[src_r];
          dst_n = dst_r - 1'b1;
        end
        src_n = src_r - 1'b1;
        if (src_r == '0) begin
          if (cnt_n == '0) begin
            state_n    = IDLE;
            clr_done_o = 1'b1;
            lc_we      = 1'b1;
            lc_d       = cnt_n;
          end else begin
            state_n = FILL;
            fill_n  = AW'(cnt_n - 1'b1);
          end
        end
      end
      FILL: begin
        we     = 1'b1;
        wa     = fill_r;
        wd     = '0;
        fill_n = fill_r - 1'b1;
        if (fill_r == '0) begin
          state_n    = IDLE;
          clr_done_o = 1'b1;
          lc_we      = 1'b1;
          lc_d       = cnt_r;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      k_r     <= '0;
      src_r   <= '0;
      dst_r   <= '0;
      cnt_r   <= '0;
      fill_r  <= '0;
      x_r     <= '0;
      y_r     <= '0;
      mask_r  <= '0;
      lc_r    <= '0;
      addr_r  <= '0;
    end else begin
      state_r <= state_n;
      k_r     <= k_n;
      src_r   <= src_n;
      dst_r   <= dst_n;
      cnt_r   <= cnt_n;
      fill_r  <= fill_n;
      if (blk_acc) begin
        x_r    <= blk_x_i;
        y_r    <= blk_y_i;
        mask_r <= blk_data_i;
      end
      if (lc_we) lc_r <= lc_d;
      for (int p = 0; p < num_line_ports_p; p++) begin
        if (line_v_i[p]) addr_r[p] <= line_addr_i[p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < height_p; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    for (int p = 0; p < num_line_ports_p; p++) begin
      line_data_o[p] = ({1'b0, addr_r[p]} < HGT) ? mem[addr_r[p]] : '1;
    end
  end

  // Outside the field reads as solid wall/floor.
  always_comb begin
    int wy, wx;
    wy = 0;
    wx = 0;
    win_data_o = '0;
    for (int r = 0; r < piece_dim_p; r++) begin
      for (int c = 0; c < piece_dim_p; c++) begin
        wy = int'(win_y_i) + r;
        wx = int'(win_x_i) + c;
        if (wy >= height_p || wx >= width_p) win_data_o[r][c] = 1'b1;
        else win_data_o[r][c] = mem[AW'(wy)][CW'(wx)];
      end
    end
  end

endmodule
